// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, runs a fixed-latency
// memory access (or rejects a misaligned word access) and returns a response.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory strobe held for MEM_LATENCY cycles
// RESP   | response presented until the CPU accepts it
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [17:0] address,
  output logic [31:0] write_data,
  output logic        byteOperation,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        signed_q, signed_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        byte_op_q, byte_op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      byte_q    <= 1'b0;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      byte_op_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      byte_q    <= byte_d;
      signed_q  <= signed_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      byte_op_q <= byte_op_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; memory-facing registers only load for a real access so
  // they keep the previous access values across a rejected request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    byte_d    = byte_q;
    signed_d  = signed_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    byte_op_d = byte_op_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          byte_d   = req_byte;
          signed_d = req_signed;
          if (!req_byte && (req_addr[1:0] != 2'b00)) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d   = ACCESS;
            cnt_d     = '0;
            addr_d    = req_addr;
            byte_op_d = req_byte;
            wdata_d   = req_byte ? {24'b0, req_wdata[7:0]} : req_wdata;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d = RESP;
          err_d   = 1'b0;
          if (write_q)     rdata_d = '0;
          else if (byte_q) rdata_d = {{24{signed_q & read_data[7]}}, read_data[7:0]};
          else             rdata_d = read_data;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready     = (state_q == IDLE) && !reset;
    resp_valid    = (state_q == RESP);
    resp_rdata    = rdata_q;
    resp_error    = err_q;
    address       = addr_q;
    write_data    = wdata_q;
    byteOperation = byte_op_q;
    memRead       = (state_q == ACCESS) && !write_q;
    memWrite      = (state_q == ACCESS) && write_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a behavioural model.
module tb_load_store_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_byte, req_signed;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [17:0] address;
  logic [31:0] write_data, read_data;
  logic        byteOperation, memRead, memWrite;

  int total = 0;
  int fails = 0;

  logic [17:0] last_addr = '0;
  logic [31:0] last_wd   = '0;
  logic        last_byte = 1'b0;

  load_store_unit #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .address(address),
    .write_data(write_data), .byteOperation(byteOperation),
    .memRead(memRead), .memWrite(memWrite), .read_data(read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    req_write  = 1'($urandom);
    req_byte   = 1'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 18'($urandom);
    req_wdata  = $urandom;
  endtask

  task automatic txn(input logic wr, input logic by, input logic sg,
                     input logic [17:0] ad, input logic [31:0] wd,
                     input logic [31:0] rd, input int hold);
    logic        mis;
    logic [31:0] mem_rd, exp_rd, exp_wd;
    int n, rc, wc;
    mis    = !by && (ad % 4 != 0);
    mem_rd = by ? (rd % 256) : rd;
    exp_wd = by ? (wd % 256) : wd;
    if (wr || mis)   exp_rd = 0;
    else if (!by)    exp_rd = mem_rd;
    else begin
      exp_rd = mem_rd;
      if (sg && exp_rd >= 128) exp_rd = exp_rd - 256;
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_byte = by; req_signed = sg;
    req_addr = ad; req_wdata = wd; read_data = $urandom;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();

    n = 0; rc = 0; wc = 0;
    while (!resp_valid && n < 40) begin
      if (memRead)  rc++;
      if (memWrite) wc++;
      if (memRead || memWrite) begin
        chk("access_addr", 32'(address), 32'(ad));
        chk("access_byteop", 32'(byteOperation), 32'(by));
        if (wr) chk("access_wdata", write_data, exp_wd);
      end
      chk("resp_valid_low", 32'(resp_valid), 32'd0);
      read_data = (n == LAT - 1) ? mem_rd : $urandom;
      scramble();
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), mis ? 32'd0 : 32'(LAT));
    chk("read_cycles", 32'(rc), (!mis && !wr) ? 32'(LAT) : 32'd0);
    chk("write_cycles", 32'(wc), (!mis && wr) ? 32'(LAT) : 32'd0);
    if (!mis) begin
      last_addr = ad; last_wd = exp_wd; last_byte = by;
    end

    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
      read_data = $urandom;
      @(posedge clk); #1;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_error", 32'(resp_error), 32'(mis));
    chk("resp_strobes", 32'({memRead, memWrite}), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("idle_valid", 32'(resp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_addr", 32'(address), 32'(last_addr));
    chk("idle_wdata", write_data, last_wd);
    chk("idle_byteop", 32'(byteOperation), 32'(last_byte));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; read_data = '0;
    req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_strobes", 32'({memRead, memWrite, byteOperation}), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    txn(1'b0, 1'b0, 1'b0, 18'h00008, 32'h0, 32'hDEADBEEF, 0);
    txn(1'b0, 1'b1, 1'b1, 18'h00005, 32'h0, 32'h00000080, 0);
    txn(1'b0, 1'b1, 1'b0, 18'h00005, 32'h0, 32'h00000080, 0);
    txn(1'b1, 1'b1, 1'b0, 18'h00003, 32'h123456AB, 32'h0, 0);
    txn(1'b0, 1'b0, 1'b0, 18'h00006, 32'h0, 32'h11111111, 0);
    txn(1'b0, 1'b0, 1'b0, 18'h00010, 32'h0, 32'hCAFEF00D, 5);
    txn(1'b1, 1'b0, 1'b0, 18'h00001, 32'h55AA55AA, 32'h0, 2);

    // Reset during the first access cycle of a store abandons it.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 18'h00020; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_write_on", 32'(memWrite), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_write_off", 32'(memWrite), 32'd0);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_addr", 32'(address), 32'd0);
    reset = 1'b0;
    last_addr = '0; last_wd = '0; last_byte = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_after_ready", 32'(req_ready), 32'd1);
      chk("rst_after_valid", 32'(resp_valid), 32'd0);
      chk("rst_after_strobe", 32'({memRead, memWrite}), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [17:0] a;
      logic        b;
      a = 18'($urandom);
      b = 1'($urandom);
      if (!b && ($urandom_range(3) != 0)) a[1:0] = 2'b00;
      txn(1'($urandom), b, 1'($urandom), a, $urandom, $urandom, $urandom_range(3));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
